// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
//   Execute-side partner of the fetch PC generator. A 2-bit saturating branch
//   history table (BHT) predicts the branch at the fetch PC. Resolved branches
//   at execute are checked against the prediction they carried. A mismatch
//   raises a one-cycle flush with the corrected PC and trains the table.
//   Saturating counters track resolved branches and mispredicts.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   stall            : pipeline hold; freezes every state element except the
//                      flush pulse, which always self-clears
//   f_is_branch,f_pc : fetch-side predecode and PC
//   jmp_pred         : combinational prediction for f_pc
//   ex_valid, ex_is_branch, ex_pred, ex_taken, ex_pc, ex_target
//                    : execute-stage branch resolution inputs
//   flush_flag       : registered one-cycle mispredict pulse
//   flush_pc         : corrected next PC, valid while flush_flag is high
//   br_cnt, miss_cnt : saturating statistics counters
// ---------------------------------------------------------------------------
module branch_resolve #(
  parameter int PC_W   = 16,
  parameter int IDX_W  = 4,
  parameter int SHADOW = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             f_is_branch,
  input  logic [PC_W-1:0]  f_pc,
  output logic             jmp_pred,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_pred,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [PC_W-1:0]  ex_target,
  output logic             flush_flag,
  output logic [PC_W-1:0]  flush_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  // 2-bit counter training: saturate at 3 when taken, at 0 when not taken.
  function automatic logic [1:0] ctr_train(input logic [1:0] c, input logic taken);
    if (taken) ctr_train = (c == 2'd3) ? c : c + 2'd1;
    else       ctr_train = (c == 2'd0) ? c : c - 2'd1;
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]       bht_q [DEPTH];
  logic [1:0]       shadow_q, shadow_d;
  logic             flush_flag_q, flush_flag_d;
  logic [PC_W-1:0]  flush_pc_q, flush_pc_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] f_idx, ex_idx;
  logic             resolve, mispred;
  logic             unused_f_pc;

  assign f_idx       = f_pc[IDX_W+1:2];
  assign ex_idx      = ex_pc[IDX_W+1:2];
  assign unused_f_pc = ^{f_pc[PC_W-1:IDX_W+2], f_pc[1:0]};

  // Prediction reads the registered table, so an update in the same cycle
  // only becomes visible on the following cycle.
  assign jmp_pred = f_is_branch & bht_q[f_idx][1];

  // Execute results that arrive while the shadow is non-zero belong to the
  // wrong path behind a flush and must not train or count.
  assign resolve = ex_valid & ex_is_branch & ~stall & (shadow_q == 2'd0);
  assign mispred = ex_pred ^ ex_taken;

  always_comb begin
    flush_flag_d = resolve & mispred;
    flush_pc_d   = flush_pc_q;
    br_cnt_d     = br_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    shadow_d     = shadow_q;

    if (resolve) br_cnt_d = sat_inc(br_cnt_q);

    if (flush_flag_d) begin
      flush_pc_d = ex_taken ? ex_target : ex_pc + PC_W'(4);
      miss_cnt_d = sat_inc(miss_cnt_q);
      shadow_d   = 2'(SHADOW);
    end else if (!stall && shadow_q != 2'd0) begin
      shadow_d = shadow_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_flag_q <= 1'b0;
      flush_pc_q   <= '0;
      br_cnt_q     <= '0;
      miss_cnt_q   <= '0;
      shadow_q     <= 2'd0;
    end else begin
      // flush_flag_d is forced low by stall, so the pulse never stretches.
      flush_flag_q <= flush_flag_d;
      flush_pc_q   <= flush_pc_d;
      br_cnt_q     <= br_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      shadow_q     <= shadow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht_q[i] <= 2'b01;
    end else if (resolve) begin
      bht_q[ex_idx] <= ctr_train(bht_q[ex_idx], ex_taken);
    end
  end

  assign flush_flag = flush_flag_q;
  assign flush_pc   = flush_pc_q;
  assign br_cnt     = br_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve
//   Directed self-checking bench for branch_resolve. Inputs change 1 ns after
//   the rising edge and outputs are sampled there too, away from the edge.
// ---------------------------------------------------------------------------
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst, stall, f_is_branch;
  logic [15:0] f_pc;
  logic        jmp_pred;
  logic        ex_valid, ex_is_branch, ex_pred, ex_taken;
  logic [15:0] ex_pc, ex_target;
  logic        flush_flag;
  logic [15:0] flush_pc, br_cnt, miss_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_resolve #(.PC_W(16), .IDX_W(4), .SHADOW(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .f_is_branch(f_is_branch), .f_pc(f_pc), .jmp_pred(jmp_pred),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pred(ex_pred),
    .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
    .flush_flag(flush_flag), .flush_pc(flush_pc),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic pred, input logic taken,
                        input logic [15:0] pc, input logic [15:0] tgt);
    ex_valid = v; ex_is_branch = 1'b1; ex_pred = pred; ex_taken = taken;
    ex_pc = pc; ex_target = tgt;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; f_is_branch = 1'b0; f_pc = 16'h0;
    set_ex(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick(); tick();
    rst = 1'b0;
    f_is_branch = 1'b1; f_pc = 16'h0010;
    #1;
    n_cmp++; if (jmp_pred !== 1'b0) begin n_fail++; $display("FAIL reset_jmp_pred got=%b exp=0", jmp_pred); end
    n_cmp++; if (flush_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flush_flag got=%b exp=0", flush_flag); end
    n_cmp++; if (flush_pc !== 16'h0) begin n_fail++; $display("FAIL reset_flush_pc got=%h exp=0000", flush_pc); end
    n_cmp++; if (br_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_br_cnt got=%0d exp=0", br_cnt); end
    n_cmp++; if (miss_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_miss_cnt got=%0d exp=0", miss_cnt); end
  endtask

  task automatic test_mispredict_taken();
    set_ex(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0040);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    n_cmp++; if (flush_flag !== 1'b1) begin n_fail++; $display("FAIL mt_flush got=%b exp=1", flush_flag); end
    n_cmp++; if (flush_pc !== 16'h0040) begin n_fail++; $display("FAIL mt_flush_pc got=%h exp=0040", flush_pc); end
    n_cmp++; if (br_cnt !== 16'd1) begin n_fail++; $display("FAIL mt_br_cnt got=%0d exp=1", br_cnt); end
    n_cmp++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL mt_miss_cnt got=%0d exp=1", miss_cnt); end
    tick();
    n_cmp++; if (flush_flag !== 1'b0) begin n_fail++; $display("FAIL mt_flush_pulse got=%b exp=0", flush_flag); end
    n_cmp++; if (flush_pc !== 16'h0040) begin n_fail++; $display("FAIL mt_flush_pc_hold got=%h exp=0040", flush_pc); end
    f_pc = 16'h0010; #1;
    n_cmp++; if (jmp_pred !== 1'b1) begin n_fail++; $display("FAIL mt_trained_pred got=%b exp=1", jmp_pred); end
    tick();  // shadow drains to zero
  endtask

  task automatic test_shadow();
    set_ex(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0100);
    tick();
    n_cmp++; if (flush_flag !== 1'b1) begin n_fail++; $display("FAIL sh_flush got=%b exp=1", flush_flag); end
    n_cmp++; if (flush_pc !== 16'h0024) begin n_fail++; $display("FAIL sh_flush_pc got=%h exp=0024", flush_pc); end
    n_cmp++; if (br_cnt !== 16'd2) begin n_fail++; $display("FAIL sh_br_cnt got=%0d exp=2", br_cnt); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (flush_flag !== 1'b0) begin n_fail++; $display("FAIL sh_ignored_flush[%0d] got=%b exp=0", i, flush_flag); end
      n_cmp++; if (br_cnt !== 16'd2) begin n_fail++; $display("FAIL sh_ignored_br[%0d] got=%0d exp=2", i, br_cnt); end
    end
    tick();
    n_cmp++; if (flush_flag !== 1'b1) begin n_fail++; $display("FAIL sh_resume_flush got=%b exp=1", flush_flag); end
    n_cmp++; if (br_cnt !== 16'd3) begin n_fail++; $display("FAIL sh_resume_br got=%0d exp=3", br_cnt); end
    n_cmp++; if (miss_cnt !== 16'd3) begin n_fail++; $display("FAIL sh_resume_miss got=%0d exp=3", miss_cnt); end
    set_ex(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick(); tick();
  endtask

  task automatic test_train();
    f_pc = 16'h0030;
    set_ex(1'b1, 1'b1, 1'b1, 16'h0030, 16'h0200);
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (br_cnt !== 16'd7) begin n_fail++; $display("FAIL tr_br_cnt got=%0d exp=7", br_cnt); end
    n_cmp++; if (flush_flag !== 1'b0) begin n_fail++; $display("FAIL tr_no_flush got=%b exp=0", flush_flag); end
    // counter 3 -> 2
    set_ex(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0200);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0200);
    #1;
    n_cmp++; if (jmp_pred !== 1'b1) begin n_fail++; $display("FAIL tr_after_nt1 got=%b exp=1", jmp_pred); end
    // counter 2 -> 1; lookup in the resolving cycle still sees the old value
    set_ex(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0200);
    #1;
    n_cmp++; if (jmp_pred !== 1'b1) begin n_fail++; $display("FAIL tr_no_bypass got=%b exp=1", jmp_pred); end
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0200);
    #1;
    n_cmp++; if (jmp_pred !== 1'b0) begin n_fail++; $display("FAIL tr_after_nt2 got=%b exp=0", jmp_pred); end
    n_cmp++; if (br_cnt !== 16'd9) begin n_fail++; $display("FAIL tr_br_cnt2 got=%0d exp=9", br_cnt); end
    f_is_branch = 1'b0; f_pc = 16'h0010; #1;
    n_cmp++; if (jmp_pred !== 1'b0) begin n_fail++; $display("FAIL tr_non_branch_pred got=%b exp=0", jmp_pred); end
    f_is_branch = 1'b1;
  endtask

  task automatic test_non_branch();
    set_ex(1'b1, 1'b1, 1'b0, 16'h0060, 16'h0300);
    ex_is_branch = 1'b0;
    tick();
    set_ex(1'b0, 1'b1, 1'b0, 16'h0060, 16'h0300);
    tick();
    n_cmp++; if (flush_flag !== 1'b0) begin n_fail++; $display("FAIL nb_flush got=%b exp=0", flush_flag); end
    n_cmp++; if (br_cnt !== 16'd9) begin n_fail++; $display("FAIL nb_br_cnt got=%0d exp=9", br_cnt); end
    n_cmp++; if (miss_cnt !== 16'd3) begin n_fail++; $display("FAIL nb_miss_cnt got=%0d exp=3", miss_cnt); end
  endtask

  task automatic test_wrap_stall_reset();
    set_ex(1'b1, 1'b1, 1'b0, 16'hFFFC, 16'h1000);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    n_cmp++; if (flush_flag !== 1'b1) begin n_fail++; $display("FAIL wr_flush got=%b exp=1", flush_flag); end
    n_cmp++; if (flush_pc !== 16'h0000) begin n_fail++; $display("FAIL wr_flush_pc got=%h exp=0000", flush_pc); end
    n_cmp++; if (br_cnt !== 16'd10) begin n_fail++; $display("FAIL wr_br_cnt got=%0d exp=10", br_cnt); end
    tick(); tick();
    // stalled mispredict: nothing may change, including the BHT entry
    stall = 1'b1;
    set_ex(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0080);
    tick(); tick();
    f_pc = 16'h0040; #1;
    n_cmp++; if (flush_flag !== 1'b0) begin n_fail++; $display("FAIL st_flush got=%b exp=0", flush_flag); end
    n_cmp++; if (br_cnt !== 16'd10) begin n_fail++; $display("FAIL st_br_cnt got=%0d exp=10", br_cnt); end
    n_cmp++; if (miss_cnt !== 16'd4) begin n_fail++; $display("FAIL st_miss_cnt got=%0d exp=4", miss_cnt); end
    n_cmp++; if (jmp_pred !== 1'b0) begin n_fail++; $display("FAIL st_bht_frozen got=%b exp=0", jmp_pred); end
    stall = 1'b0;
    tick();
    n_cmp++; if (flush_flag !== 1'b1) begin n_fail++; $display("FAIL st_release_flush got=%b exp=1", flush_flag); end
    n_cmp++; if (flush_pc !== 16'h0080) begin n_fail++; $display("FAIL st_release_pc got=%h exp=0080", flush_pc); end
    n_cmp++; if (jmp_pred !== 1'b1) begin n_fail++; $display("FAIL st_release_pred got=%b exp=1", jmp_pred); end
    // a registered flush still drops while stalled
    stall = 1'b1;
    tick();
    n_cmp++; if (flush_flag !== 1'b0) begin n_fail++; $display("FAIL st_no_stretch got=%b exp=0", flush_flag); end
    n_cmp++; if (br_cnt !== 16'd11) begin n_fail++; $display("FAIL st_br_cnt2 got=%0d exp=11", br_cnt); end
    // reset while the shadow is still loaded
    stall = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    f_pc = 16'h0010; #1;
    n_cmp++; if (flush_flag !== 1'b0) begin n_fail++; $display("FAIL rs_flush got=%b exp=0", flush_flag); end
    n_cmp++; if (flush_pc !== 16'h0000) begin n_fail++; $display("FAIL rs_flush_pc got=%h exp=0000", flush_pc); end
    n_cmp++; if (br_cnt !== 16'd0) begin n_fail++; $display("FAIL rs_br_cnt got=%0d exp=0", br_cnt); end
    n_cmp++; if (miss_cnt !== 16'd0) begin n_fail++; $display("FAIL rs_miss_cnt got=%0d exp=0", miss_cnt); end
    n_cmp++; if (jmp_pred !== 1'b0) begin n_fail++; $display("FAIL rs_bht got=%b exp=0", jmp_pred); end
    // shadow must be clear: an immediate mispredict resolves
    set_ex(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0500);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    n_cmp++; if (flush_flag !== 1'b1) begin n_fail++; $display("FAIL rs_shadow_clear got=%b exp=1", flush_flag); end
    n_cmp++; if (flush_pc !== 16'h0014) begin n_fail++; $display("FAIL rs_flush_pc2 got=%h exp=0014", flush_pc); end
    n_cmp++; if (br_cnt !== 16'd1) begin n_fail++; $display("FAIL rs_br_cnt2 got=%0d exp=1", br_cnt); end
    tick(); tick();
  endtask

  task automatic test_counter_saturation();
    set_ex(1'b1, 1'b1, 1'b1, 16'h0050, 16'h0600);
    for (int i = 0; i < 65533; i++) tick();
    n_cmp++; if (br_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre got=%h exp=fffe", br_cnt); end
    tick();
    n_cmp++; if (br_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_full got=%h exp=ffff", br_cnt); end
    tick();
    n_cmp++; if (br_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ffff", br_cnt); end
    n_cmp++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL sat_miss got=%0d exp=1", miss_cnt); end
    set_ex(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_mispredict_taken();
    test_shadow();
    test_train();
    test_non_branch();
    test_wrap_stall_reset();
    test_counter_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-side counterpart of the fetch PC generator.
- Predicts at fetch: a 2-bit saturating branch history table (BHT) supplies jmp_pred for the PC being fetched.
- Resolves at execute: compares each branch's actual outcome against the prediction it carried, raises a one-cycle flush_flag with the corrected PC on mismatch, and trains the BHT.
- Keeps saturating branch and mispredict statistics.

Parameters:
- PC_W, 16, PC width in bits.
- IDX_W, 4, BHT index width; table depth 2^IDX_W; index = pc[IDX_W+1:2].
- SHADOW, 2, cycles after a flush during which execute results are ignored (wrong-path instructions); range 1..3.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk, input, 1, clock; all state on rising edge.
- rst, input, 1, synchronous active-high reset.
- stall, input, 1, pipeline hold; freezes all state except reset.
- f_is_branch, input, 1, instruction at fetch PC is a conditional branch (predecode).
- f_pc, input, PC_W, PC currently being fetched.
- jmp_pred, output, 1, prediction for f_pc: f_is_branch & bht[idx(f_pc)][1]; combinational.
- ex_valid, input, 1, execute stage holds a valid instruction.
- ex_is_branch, input, 1, that instruction is a conditional branch.
- ex_pred, input, 1, jmp_pred value carried down the pipe with it.
- ex_taken, input, 1, actual branch outcome.
- ex_pc, input, PC_W, branch PC.
- ex_target, input, PC_W, branch target.
- flush_flag, output, 1, registered one-cycle mispredict pulse.
- flush_pc, output, PC_W, registered correct next PC; valid while flush_flag=1.
- br_cnt, output, CNT_W, resolved branch count (saturating).
- miss_cnt, output, CNT_W, mispredict count (saturating).

Behaviour:
- Reset (rst=1 at edge): all BHT entries = 2'b01 (weakly not-taken); flush_flag=0; flush_pc=0; br_cnt=0; miss_cnt=0; shadow counter=0. Reset takes precedence over stall and over any resolution that cycle. Reset mid-flush clears the flush and shadow immediately.
- Resolve event R = ex_valid & ex_is_branch & ~stall & (shadow==0).
- On R:
  - br_cnt += 1, saturating at all-ones.
  - BHT entry idx(ex_pc) updates: taken → min(c+1,3); not-taken → max(c-1,0).
  - Mispredict M = (ex_pred != ex_taken).
- On R & M, next cycle:
  - flush_flag=1.
  - flush_pc = ex_taken ? ex_target : ex_pc + 4, modulo 2^PC_W; wrap from 0xFFFC gives 0x0000.
  - miss_cnt += 1, saturating.
  - shadow loaded with SHADOW.
- flush_flag is high for exactly one cycle, then 0. flush_pc holds its last value afterwards.
- Shadow behaviour:
  - While shadow != 0 and ~stall, shadow decrements by 1 per cycle.
  - ex_* inputs are ignored while shadow != 0: no BHT training, no counting, no new flush.
  - stall freezes shadow.
- Stall:
  - When stall=1, no BHT, counter or shadow update occurs.
  - A flush_flag already registered still deasserts on the next edge, so it is never stretched by stall.
  - jmp_pred continues to track f_pc combinationally.
- Same-cycle lookup/update on one index: jmp_pred reflects the pre-update counter value (no bypass); the new value is visible from the next cycle.
- Non-branch or ex_valid=0: no effect on any state.
- Latency:
  - Prediction: 0 cycles.
  - Resolve to flush_flag: 1 cycle.
  - Resolve to BHT update visible on jmp_pred: 1 cycle.

Test Plan:
- Reset then f_is_branch=1, f_pc=0x0010 → jmp_pred=0; flush_flag=0, br_cnt=0, miss_cnt=0.
- Resolve branch at ex_pc=0x0010, ex_pred=0, ex_taken=1, ex_target=0x0040 → next cycle flush_flag=1, flush_pc=0x0040, miss_cnt=1, br_cnt=1; cycle after, flush_flag=0. A subsequent f_pc=0x0010 with f_is_branch=1 gives jmp_pred=1 (counter 2).
- Mispredict at ex_pc=0x0020 (ex_pred=1, ex_taken=0) → flush_pc=0x0024. During the next SHADOW=2 cycles, hold ex_valid=1 with a mispredicting branch → no second flush, br_cnt unchanged. Third cycle → resolves normally.
- Train entry for 0x0030 taken four times → counter saturates at 3. One not-taken → 2, jmp_pred still 1. A second not-taken → 1, jmp_pred=0.
- Mispredict at ex_pc=0xFFFC, not-taken, ex_pred=1 → flush_pc=0x0000. Assert stall with a valid mispredicting branch → no flush, counters frozen. Assert rst during shadow → all outputs return to reset values next cycle.
- Preload br_cnt to 0xFFFF via 65535 resolves (or force) → one more resolve keeps br_cnt=0xFFFF.
